// File: rtl/branch_unit.sv
// Purpose : BR resolution and PC ownership for the SLC-3 datapath. Latches a BR
//           instruction, strobes the BEN logic, then conditionally redirects PC.
// Latency : br_req at edge 0 -> ld_ben_o in cycle 1 -> PC at edge 2 -> done in cycle 3.
// Backpressure: none; br_req/pc_inc/pc_ld_bus are dropped (not queued) while busy.
//
// Ports:
//   clk, reset           clock and asynchronous active-low reset
//   br_req, ir           BR decoded pulse and the instruction it refers to
//   ben                  registered branch-enable result, valid in EVAL
//   pc_inc, pc_ld_bus    fetch increment / load-from-bus requests (IDLE only)
//   bus                  datapath bus value for pc_ld_bus
//   nzp_o, ld_ben_o      mask and load strobe toward the BEN logic
//   pc                   program counter
//   busy, done, taken    branch in flight / resolved pulse / held resolution result
module branch_unit #(
  parameter int              WIDTH    = 16,
  parameter int              OFF_W    = 9,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_req,
  input  logic [WIDTH-1:0] ir,
  input  logic             ben,
  input  logic             pc_inc,
  input  logic             pc_ld_bus,
  input  logic [WIDTH-1:0] bus,
  output logic [2:0]       nzp_o,
  output logic             ld_ben_o,
  output logic [WIDTH-1:0] pc,
  output logic             busy,
  output logic             done,
  output logic             taken
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EVAL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ir_lat;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] offset_sext;
  logic             unused_ir_lat;

  // Only the nzp and offset fields are consumed; the rest of the latched word
  // is kept so the full instruction is visible for debug.
  assign unused_ir_lat = ^ir_lat;

  assign offset_sext = {{(WIDTH-OFF_W){ir_lat[OFF_W-1]}}, ir_lat[OFF_W-1:0]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (br_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = EVAL;
      EVAL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    ld_ben_o = (state == ISSUE);
    busy     = (state != IDLE);
    nzp_o    = ir_lat[11:9];
  end

  // PC source select. In IDLE a same-cycle br_req is accepted alongside the
  // PC update, so the later branch target naturally builds on the updated PC.
  always_comb begin
    pc_nxt = pc;
    case (state)
      IDLE: begin
        if (pc_ld_bus) begin
          pc_nxt = bus;
        end else if (pc_inc) begin
          pc_nxt = pc + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      EVAL: begin
        if (ben) pc_nxt = pc + offset_sext;
      end
      default: pc_nxt = pc;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      ir_lat <= '0;
      done   <= 1'b0;
      taken  <= 1'b0;
    end else begin
      pc   <= pc_nxt;
      done <= (state == EVAL);
      if (state == IDLE && br_req) begin
        ir_lat <= ir;
      end
      if (state == EVAL) begin
        taken <= ben;
      end
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

  logic        clk;
  logic        reset;
  logic        br_req;
  logic [15:0] ir;
  logic        ben;
  logic        pc_inc;
  logic        pc_ld_bus;
  logic [15:0] bus;
  logic [2:0]  nzp_o;
  logic        ld_ben_o;
  logic [15:0] pc;
  logic        busy;
  logic        done;
  logic        taken;

  int checks = 0;
  int errors = 0;

  branch_unit #(.WIDTH(16), .OFF_W(9), .RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .br_req    (br_req),
    .ir        (ir),
    .ben       (ben),
    .pc_inc    (pc_inc),
    .pc_ld_bus (pc_ld_bus),
    .bus       (bus),
    .nzp_o     (nzp_o),
    .ld_ben_o  (ld_ben_o),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .taken     (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_ld_bus = 1'b1;
    bus       = v;
    tick();
    pc_ld_bus = 1'b0;
    bus       = 16'h0000;
    checks++;
    if (pc !== v) begin errors++; $display("FAIL load_pc got %h exp %h", pc, v); end
  endtask

  task automatic test_reset();
    reset = 1'b0; br_req = 1'b0; ir = 16'h0; ben = 1'b0;
    pc_inc = 1'b0; pc_ld_bus = 1'b0; bus = 16'h0;
    tick(); tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (ld_ben_o !== 1'b0) begin errors++; $display("FAIL reset_ld_ben got %b exp 0", ld_ben_o); end
    checks++; if (nzp_o !== 3'b000) begin errors++; $display("FAIL reset_nzp got %b exp 000", nzp_o); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", taken); end
    reset = 1'b1;
    tick(); tick();
    checks++; if (pc !== 16'h0000 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_hold pc %h busy %b exp 0000 0", pc, busy);
    end
  endtask

  task automatic test_branch_taken();
    load_pc(16'h3001);
    br_req = 1'b1; ir = 16'h0E05; ben = 1'b1;
    tick();  // edge 0 -> ISSUE
    br_req = 1'b0; ir = 16'h0000;
    checks++; if (ld_ben_o !== 1'b1) begin errors++; $display("FAIL taken_ld_ben_issue got %b exp 1", ld_ben_o); end
    checks++; if (nzp_o !== 3'b111) begin errors++; $display("FAIL taken_nzp got %b exp 111", nzp_o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL taken_busy got %b exp 1", busy); end
    tick();  // edge 1 -> EVAL
    checks++; if (ld_ben_o !== 1'b0) begin errors++; $display("FAIL taken_ld_ben_eval got %b exp 0", ld_ben_o); end
    checks++; if (pc !== 16'h3001) begin errors++; $display("FAIL taken_pc_eval got %h exp 3001", pc); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL taken_done_early got %b exp 0", done); end
    tick();  // edge 2 -> IDLE, resolved
    checks++; if (pc !== 16'h3006) begin errors++; $display("FAIL taken_pc got %h exp 3006", pc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL taken_done got %b exp 1", done); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL taken_flag got %b exp 1", taken); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL taken_busy_end got %b exp 0", busy); end
    ben = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL taken_done_pulse got %b exp 0", done); end
    checks++; if (taken !== 1'b1 || nzp_o !== 3'b111) begin
      errors++; $display("FAIL taken_hold taken %b nzp %b exp 1 111", taken, nzp_o);
    end
  endtask

  task automatic test_branch_not_taken();
    load_pc(16'h3001);
    br_req = 1'b1; ir = 16'h05FD; ben = 1'b0;
    tick();
    br_req = 1'b0;
    checks++; if (nzp_o !== 3'b010) begin errors++; $display("FAIL nt_nzp got %b exp 010", nzp_o); end
    tick();
    tick();
    checks++; if (pc !== 16'h3001) begin errors++; $display("FAIL nt_pc got %h exp 3001", pc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL nt_done got %b exp 1", done); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL nt_taken got %b exp 0", taken); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL nt_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_wrap();
    load_pc(16'hFFFE);
    br_req = 1'b1; ir = 16'h0E04; ben = 1'b1;
    tick();
    br_req = 1'b0;
    tick(); tick();
    ben = 1'b0;
    checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL wrap_branch got %h exp 0002", pc); end
    tick();
    load_pc(16'hFFFF);
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_inc got %h exp 0000", pc); end
  endtask

  task automatic test_reset_mid_issue();
    load_pc(16'h1234);
    br_req = 1'b1; ir = 16'h0E05; ben = 1'b1;
    tick();  // now in ISSUE with taken=1 from previous branches? ensure state
    br_req = 1'b0;
    checks++; if (ld_ben_o !== 1'b1) begin errors++; $display("FAIL mid_pre_issue got %b exp 1", ld_ben_o); end
    #2;
    reset = 1'b0;
    #1;  // no clock edge between assertion and sampling
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL mid_pc got %h exp 0000", pc); end
    checks++; if (ld_ben_o !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_fsm ld_ben %b busy %b exp 0 0", ld_ben_o, busy);
    end
    checks++; if (nzp_o !== 3'b000 || taken !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_out nzp %b taken %b done %b exp 000 0 0", nzp_o, taken, done);
    end
    ben = 1'b0;
    #1;
    reset = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0 || pc !== 16'h0000) begin
      errors++; $display("FAIL mid_after busy %b pc %h exp 0 0000", busy, pc);
    end
  endtask

  task automatic test_same_cycle();
    load_pc(16'h1000);
    pc_inc = 1'b1; br_req = 1'b1; ir = 16'h0E02; ben = 1'b1;
    tick();
    pc_inc = 1'b0; br_req = 1'b0;
    checks++; if (pc !== 16'h1001) begin errors++; $display("FAIL same_inc got %h exp 1001", pc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_accept got %b exp 1", busy); end
    tick(); tick();
    ben = 1'b0;
    checks++; if (pc !== 16'h1003) begin errors++; $display("FAIL same_target got %h exp 1003", pc); end
    tick();
    pc_ld_bus = 1'b1; pc_inc = 1'b1; bus = 16'h4000;
    tick();
    pc_ld_bus = 1'b0; pc_inc = 1'b0; bus = 16'h0000;
    checks++; if (pc !== 16'h4000) begin errors++; $display("FAIL ld_priority got %h exp 4000", pc); end
  endtask

  task automatic test_back_to_back();
    load_pc(16'h2000);
    br_req = 1'b1; ir = 16'h0E01; ben = 1'b1;
    tick();  // ISSUE: hammer requests that must be dropped
    ir = 16'h0210; pc_inc = 1'b1; pc_ld_bus = 1'b1; bus = 16'h5555;
    tick();  // EVAL
    checks++; if (nzp_o !== 3'b111) begin errors++; $display("FAIL b2b_nzp_hold got %b exp 111", nzp_o); end
    checks++; if (pc !== 16'h2000) begin errors++; $display("FAIL b2b_ignored got %h exp 2000", pc); end
    pc_inc = 1'b0; pc_ld_bus = 1'b0; bus = 16'h0000;
    tick();  // done cycle: new request accepted here
    checks++; if (pc !== 16'h2001 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_first pc %h done %b exp 2001 1", pc, done);
    end
    br_req = 1'b1; ir = 16'h0E03; ben = 1'b1;
    tick();
    br_req = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || ld_ben_o !== 1'b1) begin
      errors++; $display("FAIL b2b_accept busy %b done %b ld_ben %b exp 1 0 1", busy, done, ld_ben_o);
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_early got %b exp 0", done); end
    tick();
    checks++; if (pc !== 16'h2004 || done !== 1'b1 || taken !== 1'b1) begin
      errors++; $display("FAIL b2b_second pc %h done %b taken %b exp 2004 1 1", pc, done, taken);
    end
    ben = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_branch_taken();
    test_branch_not_taken();
    test_wrap();
    test_reset_mid_issue();
    test_same_cycle();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
